// File: rtl/apb_mon_pkg.sv
// Shared definitions for the APB protocol monitor: FSM states and the
// error-vector bit layout.
package apb_mon_pkg;

  localparam int ERR_W = 8;

  localparam int ERR_SEL_MULTI      = 0;
  localparam int ERR_PEN_NO_SEL     = 1;
  localparam int ERR_PEN_IN_SETUP   = 2;
  localparam int ERR_NO_ACCESS      = 3;
  localparam int ERR_CTRL_UNSTABLE  = 4;
  localparam int ERR_WDATA_UNSTABLE = 5;
  localparam int ERR_TIMEOUT        = 6;
  localparam int ERR_X_DETECT       = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mon_sat_ctr.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count sticks at all-ones.
module apb_mon_sat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol checker: tracks IDLE/SETUP/ACCESS, flags sticky
// protocol errors and keeps transfer statistics. APB_MON_XCHK_EN adds X checks.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int NSEL    = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [NSEL-1:0]  psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [AW-1:0]    paddr,
  input  logic [DW-1:0]    pwdata,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_vec,
  output logic             err_pulse,
  output logic             txn_done,
  output logic             txn_err,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [7:0]       wait_max
);

  localparam int SW = (NSEL > 1) ? $clog2(NSEL) : 1;
  localparam int CW = $clog2(NSEL + 1);

  apb_state_e       state, state_n;
  logic [SW-1:0]    sel_p0;
  logic [AW-1:0]    addr_p0;
  logic             write_p0;
  logic [DW-1:0]    wdata_p0;

  logic [CW-1:0]    sel_cnt;
  logic [SW-1:0]    sel_idx;
  logic             sel_any, sel_one, sel_multi, sel_same;
  logic [NSEL-1:0]  sel_mask;
  logic [7:0]       wait_cnt;
  logic [8:0]       wait_nxt;
  logic             complete, capture;
  logic [ERR_W-1:0] det;

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < NSEL; i++) begin
      if (psel[i]) begin
        sel_cnt = sel_cnt + CW'(1);
        sel_idx = SW'(i);
      end
    end
  end

  assign sel_any   = |psel;
  assign sel_one   = (sel_cnt == CW'(1));
  assign sel_multi = (sel_cnt > CW'(1));
  assign sel_mask  = NSEL'(1) << sel_p0;
  assign sel_same  = (psel == sel_mask);
  // wait_cnt is held at 0 through SETUP, so +1 gives the count for this edge.
  assign wait_nxt  = {1'b0, wait_cnt} + 9'd1;

  always_comb begin
    state_n  = state;
    det      = '0;
    complete = 1'b0;
    capture  = 1'b0;

    if (!sel_any && penable) det[ERR_PEN_NO_SEL] = 1'b1;

    case (state)
      ST_IDLE: begin
        if (sel_any && penable) begin
          det[ERR_PEN_IN_SETUP] = 1'b1;
        end else if (sel_one) begin
          state_n = ST_SETUP;
          capture = 1'b1;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (sel_same) begin
          if ((paddr != addr_p0) || (pwrite != write_p0)) det[ERR_CTRL_UNSTABLE] = 1'b1;
          if (write_p0 && (pwdata != wdata_p0)) det[ERR_WDATA_UNSTABLE] = 1'b1;
        end
        if (sel_same && penable) begin
          if (pready) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
          end else if (wait_nxt >= 9'(TIMEOUT)) begin
            det[ERR_TIMEOUT] = 1'b1;
            state_n          = ST_IDLE;
          end else begin
            state_n = ST_ACCESS;
          end
        end else begin
          det[ERR_NO_ACCESS] = 1'b1;
          state_n            = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (sel_multi) begin
      det[ERR_SEL_MULTI] = 1'b1;
      state_n            = ST_IDLE;
      complete           = 1'b0;
      capture            = 1'b0;
    end

`ifdef APB_MON_XCHK_EN
    if ($isunknown({psel, penable, pwrite, pready})            ||
        (sel_any && $isunknown(paddr))                          ||
        (sel_any && pwrite && $isunknown(pwdata))               ||
        (complete && !write_p0 && $isunknown(prdata))           ||
        (pready && $isunknown(pslverr)))
      det[ERR_X_DETECT] = 1'b1;
`endif
  end

`ifndef APB_MON_XCHK_EN
  logic unused_prdata;
  assign unused_prdata = ^prdata;
`endif

  // Stage boundary: FSM, captured control and registered outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= ST_IDLE;
      sel_p0    <= '0;
      addr_p0   <= '0;
      write_p0  <= 1'b0;
      wdata_p0  <= '0;
      err_vec   <= '0;
      err_pulse <= 1'b0;
      txn_done  <= 1'b0;
      txn_err   <= 1'b0;
      wait_max  <= '0;
    end else begin
      state     <= state_n;
      if (capture) begin
        sel_p0   <= sel_idx;
        addr_p0  <= paddr;
        write_p0 <= pwrite;
        wdata_p0 <= pwdata;
      end
      err_vec   <= (err_clr ? '0 : err_vec) | det;
      err_pulse <= |(det & ~err_vec);
      txn_done  <= complete;
      txn_err   <= complete & pslverr;
      if (complete && (wait_cnt > wait_max)) wait_max <= wait_cnt;
    end
  end

  apb_mon_sat_ctr #(.W(CNT_W)) u_txn_ctr (
    .clk   (pclk),
    .rst_n (preset_n),
    .clr   (1'b0),
    .inc   (complete),
    .cnt   (txn_cnt)
  );

  apb_mon_sat_ctr #(.W(8)) u_wait_ctr (
    .clk   (pclk),
    .rst_n (preset_n),
    .clr   (state_n != ST_ACCESS),
    .inc   (state_n == ST_ACCESS),
    .cnt   (wait_cnt)
  );

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed APB traffic with a completion
// scoreboard plus direct error-vector checks.
module tb_apb_protocol_monitor;

  localparam int AW = 6, DW = 32, NSEL = 4, TMO = 4, CNT_W = 16;

  logic             pclk = 1'b0;
  logic             preset_n;
  logic [NSEL-1:0]  psel;
  logic             penable, pwrite, pready, pslverr, err_clr;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata, prdata;
  logic [7:0]       err_vec;
  logic             err_pulse, txn_done, txn_err;
  logic [CNT_W-1:0] txn_cnt;
  logic [7:0]       wait_max;

  typedef struct packed {
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       wmax;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  int   model_wmax = 0;

  always #5 pclk = ~pclk;

  apb_protocol_monitor #(
    .AW(AW), .DW(DW), .NSEL(NSEL), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .err_clr(err_clr),
    .err_vec(err_vec), .err_pulse(err_pulse), .txn_done(txn_done),
    .txn_err(txn_err), .txn_cnt(txn_cnt), .wait_max(wait_max)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic push_exp(input logic err, input int waits);
    exp_t e;
    if (model_cnt < 65535) model_cnt++;
    if (waits > model_wmax) model_wmax = waits;
    e.err  = err;
    e.cnt  = CNT_W'(model_cnt);
    e.wmax = 8'(model_wmax);
    exp_q.push_back(e);
  endtask

  task automatic apb_xfer(input int idx, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int waits, input logic slverr);
    push_exp(slverr, waits);
    psel = NSEL'(1 << idx); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h1234_5678;
    step();
    penable = 1'b1;
    for (int i = 0; i < waits; i++) step();
    pready = 1'b1; pslverr = slverr;
    step();
    check_val("done_set", {31'd0, txn_done}, 32'd1);
    bus_idle();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_val("err_cleared", {24'd0, err_vec}, 32'd0);
  endtask

  // Completion scoreboard
  always @(negedge pclk) begin
    if (preset_n && txn_done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("txn_err", {31'd0, txn_err}, {31'd0, e.err});
        check_val("txn_cnt", {16'd0, txn_cnt}, {16'd0, e.cnt});
        check_val("wait_max", {24'd0, wait_max}, {24'd0, e.wmax});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0; err_clr = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; prdata = '0;
    bus_idle();
    repeat (3) step();
    check_val("rst_err_vec", {24'd0, err_vec}, 32'd0);
    check_val("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check_val("rst_txn_done", {31'd0, txn_done}, 32'd0);
    check_val("rst_txn_err", {31'd0, txn_err}, 32'd0);
    check_val("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
    check_val("rst_wait_max", {24'd0, wait_max}, 32'd0);
    preset_n = 1'b1;
    step();

    // Zero-wait write
    apb_xfer(0, 1'b1, 6'h10, 32'hA5A5_A5A5, 0, 1'b0);
    step();
    check_val("done_one_cycle", {31'd0, txn_done}, 32'd0);
    check_val("wr_err_vec", {24'd0, err_vec}, 32'd0);

    // Read with three wait states and slave error
    apb_xfer(2, 1'b0, 6'h08, 32'h0, 3, 1'b1);
    step();
    check_val("rd_err_vec", {24'd0, err_vec}, 32'd0);

    // Two select lines at once
    psel = 4'b0110;
    step();
    bus_idle();
    check_val("multi_err_vec", {24'd0, err_vec}, 32'h01);
    check_val("multi_pulse", {31'd0, err_pulse}, 32'd1);
    step();
    check_val("multi_pulse_end", {31'd0, err_pulse}, 32'd0);
    check_val("multi_sticky", {24'd0, err_vec}, 32'h01);
    clear_errs();

    // Address changes during the access phase; transfer still completes
    push_exp(1'b0, 1);
    psel = 4'b0001; penable = 1'b0; pwrite = 1'b0; paddr = 6'h10;
    step();
    penable = 1'b1; paddr = 6'h14;
    step();
    check_val("ctrl_pulse", {31'd0, err_pulse}, 32'd1);
    pready = 1'b1;
    step();
    check_val("ctrl_done", {31'd0, txn_done}, 32'd1);
    check_val("ctrl_err_vec", {24'd0, err_vec}, 32'h10);
    check_val("ctrl_pulse_end", {31'd0, err_pulse}, 32'd0);
    bus_idle();
    clear_errs();

    // Error detected in the same cycle as a clear wins
    penable = 1'b1; err_clr = 1'b1;
    step();
    bus_idle(); err_clr = 1'b0;
    check_val("clr_vs_set", {24'd0, err_vec}, 32'h02);
    clear_errs();

    // penable asserted together with a fresh select
    psel = 4'b1000; penable = 1'b1;
    step();
    bus_idle();
    check_val("pen_in_setup", {24'd0, err_vec}, 32'h04);
    clear_errs();

    // Select dropped before the access phase
    psel = 4'b0001; pwrite = 1'b1; paddr = 6'h20; pwdata = 32'h1;
    step();
    bus_idle();
    step();
    check_val("no_access", {24'd0, err_vec}, 32'h08);
    clear_errs();

    // Write data changes during the access phase
    push_exp(1'b0, 0);
    psel = 4'b0001; pwrite = 1'b1; paddr = 6'h04; pwdata = 32'hDEAD_0000;
    step();
    penable = 1'b1; pready = 1'b1; pwdata = 32'hDEAD_0001;
    step();
    bus_idle();
    check_val("wdata_unstable", {24'd0, err_vec}, 32'h20);
    clear_errs();

    // Slave never ready: timeout on the fourth wait cycle
    psel = 4'b0010; pwrite = 1'b0; paddr = 6'h30;
    step();
    penable = 1'b1;
    repeat (3) step();
    check_val("pre_timeout", {24'd0, err_vec}, 32'h00);
    step();
    check_val("timeout", {24'd0, err_vec}, 32'h40);
    step();
    check_val("idle_after_tmo", {24'd0, err_vec}, 32'h44);
    bus_idle();
    step();

    // Reset in the middle of a transfer discards it
    psel = 4'b0001; pwrite = 1'b1; paddr = 6'h11; pwdata = 32'h5;
    step();
    penable = 1'b1;
    repeat (2) step();
    preset_n = 1'b0;
    pready = 1'b1;
    #2;
    check_val("mid_rst_err_vec", {24'd0, err_vec}, 32'd0);
    check_val("mid_rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
    check_val("mid_rst_wait_max", {24'd0, wait_max}, 32'd0);
    check_val("mid_rst_done", {31'd0, txn_done}, 32'd0);
    step();
    bus_idle();
    step();
    preset_n = 1'b1;
    model_cnt = 0;
    model_wmax = 0;
    step();
    check_val("post_rst_done", {31'd0, txn_done}, 32'd0);
    check_val("post_rst_err_vec", {24'd0, err_vec}, 32'd0);

    apb_xfer(3, 1'b1, 6'h3F, 32'hFFFF_0000, 1, 1'b0);
    repeat (2) step();
    check_val("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
